branch_redirect_ctrl: RTL and testbench

Recovery controller directly downstream of the mispredict priority picker in the 4-wide branch resolution path. It consumes the selected mispredicted slot and that slot's resolved target, then issues a held redirect to fetch over a valid/ready handshake. It also squashes younger instructions and stalls issue until the front end has drained.

---
 rtl/branch_pkg.sv | 8 +
 rtl/sat_counter.sv | 14 +
 rtl/branch_redirect_ctrl.sv | 67 ++++++
 tb/tb_branch_redirect_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch recovery path
package branch_pkg;
    localparam int SLOT_N = 4;
    localparam int TARGET_W = 32;
    typedef logic [1:0] slot_idx_t;
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} redir_state_t;
    typedef logic [SLOT_N-1:0][TARGET_W-1:0] slot_target_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    // count up on inc, holding once every bit is set
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: captures a mispredict, issues a held redirect, then drains
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mis_valid,
    input  logic [1:0]                   mis_slot,
    input  logic [SLOT_N-1:0][PC_W-1:0]  slot_target,
    output logic                         redirect_valid,
    output logic [PC_W-1:0]              redirect_pc,
    input  logic                         redirect_ready,
    output logic                         flush_front,
    output logic [SLOT_N-1:0]            flush_mask,
    output logic                         stall_issue,
    output logic [CNT_W-1:0]             mispred_count
);
    redir_state_t state, state_nxt;
    logic [3:0]   drain_cnt;
    logic         capture;
    assign capture = state == IDLE && mis_valid;
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    // next-state: a branch seen outside IDLE belongs to the squashed path
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (mis_valid) state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready) state_nxt = DRAIN;
            DRAIN:    if (drain_cnt <= 4'd1) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
    // outputs decoded from registered state only, so ready never reaches valid
    always_comb begin
        redirect_valid = state == REDIRECT;
        stall_issue    = state != IDLE;
    end
    // capture target and squash mask; flush signals live for the first REDIRECT cycle only
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            redirect_pc <= '0;
            flush_front <= 1'b0;
            flush_mask  <= '0;
        end else begin
            redirect_pc <= capture ? slot_target[mis_slot] : redirect_pc;
            flush_front <= capture;
            flush_mask  <= capture ? 4'(~((5'd2 << mis_slot) - 5'd1)) : '0;
        end
    // drain down-counter, armed by the redirect handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) drain_cnt <= '0;
        else if (state == REDIRECT && redirect_ready) drain_cnt <= 4'(DRAIN_CYCLES);
        else if (state == DRAIN) drain_cnt <= drain_cnt - 4'd1;
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (capture),
        .count (mispred_count)
    );
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed and random checks against a timeline model
module tb_branch_redirect_ctrl;
    localparam int D = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic mis_valid = 1'b0;
    logic [1:0] mis_slot = '0;
    logic [3:0][31:0] tgt = '0;
    logic redirect_ready = 1'b0;
    logic redirect_valid, flush_front, stall_issue;
    logic [31:0] redirect_pc;
    logic [3:0] flush_mask;
    logic [15:0] mispred_count;
    logic s_valid, s_flush, s_stall;
    logic [31:0] s_pc;
    logic [3:0] s_mask;
    logic [1:0] s_count;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic m_pend = 1'b0;
    logic m_flush = 1'b0;
    logic [3:0] m_mask = '0;
    logic [31:0] m_pc = '0;
    int m_rel = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.PC_W(32), .DRAIN_CYCLES(D), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .mis_valid(mis_valid), .mis_slot(mis_slot),
        .slot_target(tgt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush_front(flush_front), .flush_mask(flush_mask),
        .stall_issue(stall_issue), .mispred_count(mispred_count)
    );

    branch_redirect_ctrl #(.PC_W(32), .DRAIN_CYCLES(D), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .mis_valid(mis_valid), .mis_slot(mis_slot),
        .slot_target(tgt), .redirect_valid(s_valid), .redirect_pc(s_pc),
        .redirect_ready(redirect_ready), .flush_front(s_flush), .flush_mask(s_mask),
        .stall_issue(s_stall), .mispred_count(s_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] younger(input int s);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = i > s;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // timeline model: a capture opens a pending redirect; a handshake sets the cycle idle resumes
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_pend <= 1'b0; m_flush <= 1'b0; m_mask <= '0; m_pc <= '0; m_rel <= 0; m_cnt <= 0;
        end else begin
            m_flush <= 1'b0;
            m_mask <= '0;
            if (!m_pend && cyc >= m_rel && mis_valid) begin
                m_pend <= 1'b1;
                m_pc <= tgt[mis_slot];
                m_mask <= younger(int'(mis_slot));
                m_flush <= 1'b1;
                m_cnt <= m_cnt + 1;
            end else if (m_pend && redirect_ready) begin
                m_pend <= 1'b0;
                m_rel <= cyc + D + 1;
            end
        end

    always @(negedge clk) begin
        chk("valid", redirect_valid, m_pend);
        chk("stall", stall_issue, m_pend || cyc < m_rel);
        chk("pc", redirect_pc, m_pc);
        chk("flush_front", flush_front, m_flush);
        chk("flush_mask", flush_mask, m_mask);
        chk("count", mispred_count, m_cnt > 65535 ? 65535 : m_cnt);
        chk("count_sat", s_count, m_cnt > 3 ? 3 : m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (stall_issue && n < 50) begin
            n++;
            tick();
        end
        chk("idle_timeout", n < 50, 1'b1);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_valid", redirect_valid, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_stall", stall_issue, 0);
        chk("rst_count", mispred_count, 0);
        rst_n = 1'b1;
        tick();
        // slot 2 with ready already high: minimum recovery
        mis_valid = 1'b1; mis_slot = 2'd2; tgt[2] = 32'h0000_4000; redirect_ready = 1'b1;
        tick();
        mis_valid = 1'b0;
        chk("d1_pc", redirect_pc, 32'h4000);
        chk("d1_mask", flush_mask, 4'b1000);
        chk("d1_flush", flush_front, 1);
        chk("d1_count", mispred_count, 1);
        chk("d1_model_pc", m_pc, 32'h4000);
        chk("d1_model_mask", m_mask, 4'b1000);
        n = 0;
        while (stall_issue && n < 20) begin
            n++;
            tick();
        end
        chk("d1_stall_len", n, 1 + D);
        redirect_ready = 1'b0;
        // slot 0 with ready low, plus mispredicts during REDIRECT that must be ignored
        mis_valid = 1'b1; mis_slot = 2'd0; tgt[0] = 32'h1234_5670;
        tick();
        chk("d2_pc", redirect_pc, 32'h1234_5670);
        chk("d2_mask", flush_mask, 4'b1110);
        chk("d2_count", mispred_count, 2);
        mis_slot = 2'd3; tgt[3] = 32'hdead_beef;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("d2_hold_valid", redirect_valid, 1);
            chk("d2_hold_pc", redirect_pc, 32'h1234_5670);
            chk("d2_hold_mask", flush_mask, 4'b0000);
            chk("d2_hold_flush", flush_front, 0);
            chk("d2_hold_count", mispred_count, 2);
        end
        redirect_ready = 1'b1;
        tick();
        // mis_valid held through DRAIN; accepted on the first idle cycle
        redirect_ready = 1'b0; tgt[3] = 32'h0000_8000;
        for (int i = 0; i < D; i++) begin
            chk("d3_drain_valid", redirect_valid, 0);
            chk("d3_drain_stall", stall_issue, 1);
            chk("d3_drain_pc", redirect_pc, 32'h1234_5670);
            chk("d3_drain_count", mispred_count, 2);
            tick();
        end
        chk("d3_idle_stall", stall_issue, 0);
        tick();
        mis_valid = 1'b0;
        chk("d3_pc", redirect_pc, 32'h8000);
        chk("d3_mask", flush_mask, 4'b0000);
        chk("d3_flush", flush_front, 1);
        chk("d3_count", mispred_count, 3);
        chk("d3_model_count", m_cnt, 3);
        // asynchronous reset in the middle of REDIRECT
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", redirect_valid, 0);
        chk("ar_pc", redirect_pc, 0);
        chk("ar_flush", flush_front, 0);
        chk("ar_mask", flush_mask, 0);
        chk("ar_stall", stall_issue, 0);
        chk("ar_count", mispred_count, 0);
        chk("ar_count_sat", s_count, 0);
        tick();
        rst_n = 1'b1;
        mis_valid = 1'b1; mis_slot = 2'd1; tgt[1] = 32'h0000_2220; redirect_ready = 1'b1;
        tick();
        mis_valid = 1'b0;
        chk("ar_new_pc", redirect_pc, 32'h2220);
        chk("ar_new_mask", flush_mask, 4'b1100);
        chk("ar_new_count", mispred_count, 1);
        wait_idle();
        // saturation of the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            mis_valid = 1'b1; mis_slot = 2'($urandom);
            tick();
            mis_valid = 1'b0;
            wait_idle();
        end
        chk("sat_small", s_count, 2'd3);
        chk("sat_big", mispred_count, 5);
        // random traffic against the model, with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            mis_valid = $urandom_range(0, 2) == 0;
            mis_slot = 2'($urandom);
            for (int k = 0; k < 4; k++) tgt[k] = $urandom;
            redirect_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
